conv_maxpool_stage: RTL and testbench

Standalone 2x2/stride-2 max-pooling engine for the CNN accelerator's layer-1 stage. It runs after the convolution stage has filled layer-0 memory with a 64x64 map of 20-bit samples. It reads that map through the shared `crd`/`caddr_rd`/`csel` port, writes a 32x32 pooled map into layer-1 memory through `cwr`/`caddr_wr`/`csel`, and brackets the whole run with a `ready`/`busy` handshake.

---
 rtl/conv_pkg.sv | 10 +
 rtl/conv_maxpool_stage_if.sv | 24 ++
 rtl/pool_addr_gen.sv | 16 +
 rtl/conv_maxpool_stage.sv | 142 ++++++++++++++
 tb/tb_conv_maxpool_stage.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the CNN accelerator conv/pool stages.
package conv_pkg;
  localparam int DW = 20;
  localparam int AW = 12;
  localparam logic [2:0] CSEL_L0 = 3'b001;
  localparam logic [2:0] CSEL_L1 = 3'b011;

  typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, WR} pool_state_t;
  typedef logic signed [DW-1:0] sample_t;
endpackage

// File: rtl/conv_maxpool_stage_if.sv
// Start/busy handshake plus the shared layer-memory read/write port.
interface conv_maxpool_stage_if #(
  parameter int DW = conv_pkg::DW,
  parameter int AW = conv_pkg::AW
);
  logic          ready;
  logic          busy;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic [2:0]    csel;

  modport master (
    input  ready, cdata_rd,
    output busy, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
  );
  modport slave (
    output ready, cdata_rd,
    input  busy, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
  );
endinterface

// File: rtl/pool_addr_gen.sv
// Combinational address map: (r, c, quadrant) -> L0 read address, (r, c) -> L1 write address.
module pool_addr_gen #(
  parameter int IMG_W = 64,
  parameter int AW    = 12,
  parameter int RCW   = $clog2(IMG_W/2)
) (
  input  logic [RCW-1:0] r,
  input  logic [RCW-1:0] c,
  input  logic [1:0]     quad,
  output logic [AW-1:0]  rd_addr,
  output logic [AW-1:0]  wr_addr
);
  // IMG_W is a power of two, so row*IMG_W + col is a plain bit concatenation
  assign rd_addr = AW'({r, quad[1], c, quad[0]});
  assign wr_addr = AW'({r, c});
endmodule

// File: rtl/conv_maxpool_stage.sv
// 2x2/stride-2 max-pool engine, L0 map -> L1 map, five cycles per output pixel.
// Define MAXPOOL_RELU_EN to clamp negative maxima to zero on write.
module conv_maxpool_stage #(
  parameter int         IMG_W   = 64,
  parameter int         DW      = conv_pkg::DW,
  parameter int         AW      = conv_pkg::AW,
  parameter logic [2:0] SRC_SEL = conv_pkg::CSEL_L0,
  parameter logic [2:0] DST_SEL = conv_pkg::CSEL_L1
) (
  input logic clk,
  input logic reset,
  conv_maxpool_stage_if.master bus
);
  import conv_pkg::*;

  localparam int RCW = $clog2(IMG_W/2);
  localparam logic [RCW-1:0] LAST = RCW'(IMG_W/2 - 1);

  pool_state_t           state_q, state_d;
  logic [RCW-1:0]        r_q, r_d, c_q, c_d;
  logic signed [DW-1:0]  max_q, max_d, wdata;
  logic                  upd;
  logic [1:0]            quad_d;
  logic [AW-1:0]         rd_addr, wr_addr;

  logic                  busy_q, busy_d, crd_q, crd_d, cwr_q, cwr_d;
  logic [AW-1:0]         caddr_rd_q, caddr_rd_d, caddr_wr_q, caddr_wr_d;
  logic [DW-1:0]         cdata_wr_q, cdata_wr_d;
  logic [2:0]            csel_q, csel_d;

  assign upd = $signed(bus.cdata_rd) > max_q;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    max_d   = max_q;
    case (state_q)
      IDLE: if (bus.ready) begin
        state_d = RD0;
        r_d     = '0;
        c_d     = '0;
      end
      RD0: begin
        state_d = RD1;
        max_d   = bus.cdata_rd;
      end
      RD1: begin
        state_d = RD2;
        if (upd) max_d = bus.cdata_rd;
      end
      RD2: begin
        state_d = RD3;
        if (upd) max_d = bus.cdata_rd;
      end
      RD3: begin
        state_d = WR;
        if (upd) max_d = bus.cdata_rd;
      end
      WR: begin
        if (r_q == LAST && c_q == LAST) begin
          state_d = IDLE;
        end else begin
          state_d = RD0;
          if (c_q == LAST) begin
            c_d = '0;
            r_d = r_q + 1'b1;
          end else begin
            c_d = c_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the next-state view
  always_comb begin
    case (state_d)
      RD1:     quad_d = 2'd1;
      RD2:     quad_d = 2'd2;
      RD3:     quad_d = 2'd3;
      default: quad_d = 2'd0;
    endcase
  end

  pool_addr_gen #(.IMG_W(IMG_W), .AW(AW), .RCW(RCW)) u_addr (
    .r(r_d), .c(c_d), .quad(quad_d), .rd_addr(rd_addr), .wr_addr(wr_addr)
  );

`ifdef MAXPOOL_RELU_EN
  assign wdata = max_d[DW-1] ? '0 : max_d;
`else
  assign wdata = max_d;
`endif

  always_comb begin
    busy_d     = state_d != IDLE;
    crd_d      = state_d inside {RD0, RD1, RD2, RD3};
    cwr_d      = state_d == WR;
    caddr_rd_d = crd_d ? rd_addr : '0;
    caddr_wr_d = cwr_d ? wr_addr : '0;
    cdata_wr_d = cwr_d ? wdata : '0;
    csel_d     = crd_d ? SRC_SEL : (cwr_d ? DST_SEL : 3'b000);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      r_q        <= '0;
      c_q        <= '0;
      max_q      <= '0;
      busy_q     <= 1'b0;
      crd_q      <= 1'b0;
      cwr_q      <= 1'b0;
      caddr_rd_q <= '0;
      caddr_wr_q <= '0;
      cdata_wr_q <= '0;
      csel_q     <= '0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      c_q        <= c_d;
      max_q      <= max_d;
      busy_q     <= busy_d;
      crd_q      <= crd_d;
      cwr_q      <= cwr_d;
      caddr_rd_q <= caddr_rd_d;
      caddr_wr_q <= caddr_wr_d;
      cdata_wr_q <= cdata_wr_d;
      csel_q     <= csel_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.crd      = crd_q;
  assign bus.cwr      = cwr_q;
  assign bus.caddr_rd = caddr_rd_q;
  assign bus.caddr_wr = caddr_wr_q;
  assign bus.cdata_wr = cdata_wr_q;
  assign bus.csel     = csel_q;
endmodule

// File: tb/tb_conv_maxpool_stage.sv
// Scoreboarded bench: stimulus queues expected L1 writes, a negedge monitor checks every bus cycle.
module tb_conv_maxpool_stage;
  import conv_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  conv_maxpool_stage_if bus ();
  conv_maxpool_stage dut (.clk(clk), .reset(reset), .bus(bus));

  sample_t     l0 [4096];
  logic [19:0] l1 [4096];
  logic [31:0] exp_q [$];
  int total = 0, fails = 0, wcnt = 0, rd_idx = 0;
  logic prev_busy = 1'b0;

  assign bus.cdata_rd = l0[bus.caddr_rd];
  always @(posedge clk) if (bus.cwr && bus.csel == 3'b011) l1[bus.caddr_wr] <= bus.cdata_wr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input int k);
    int o, q, r, c;
    o = (k / 4) % 1024;
    q = k % 4;
    r = o / 32;
    c = o % 32;
    return 32'((2 * r + q / 2) * 64 + 2 * c + q % 2);
  endfunction

  // Protocol and scoreboard monitor
  always @(negedge clk) begin
    logic [31:0] e;
    if (reset) begin
      rd_idx    = 0;
      prev_busy = 1'b0;
    end else begin
      if (bus.busy && !prev_busy) rd_idx = 0;
      prev_busy = bus.busy;
      if (bus.crd || bus.cwr) chk("rd_wr_excl", 32'(bus.crd & bus.cwr), 32'd0);
      if (bus.crd) begin
        chk("csel_rd", 32'(bus.csel), 32'h1);
        chk("caddr_rd", 32'(bus.caddr_rd), exp_rd(rd_idx));
        rd_idx++;
      end
      if (bus.cwr) begin
        wcnt++;
        chk("csel_wr", 32'(bus.csel), 32'h3);
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("caddr_wr", 32'(bus.caddr_wr), 32'(e[31:20]));
          chk("cdata_wr", 32'(bus.cdata_wr), 32'(e[19:0]));
        end
      end
    end
  end

  task automatic push_run(input logic [19:0] px0, input logic ramp);
    for (int k = 0; k < 1024; k++) begin
      logic [19:0] d;
      if (ramp) d = 20'((2 * (k / 32) + 1) * 64 + 2 * (k % 32) + 1);
      else      d = (k == 0) ? px0 : 20'h0;
      exp_q.push_back({12'(k), d});
    end
  endtask

  task automatic fill_quad(input logic [19:0] a, b, cc, d);
    for (int i = 0; i < 4096; i++) l0[i] = '0;
    l0[0] = a; l0[1] = b; l0[64] = cc; l0[65] = d;
  endtask

  task automatic run(input string nm, input bit toggle);
    int bcnt;
    @(negedge clk) bus.ready = 1'b1;
    wcnt = 0;
    @(negedge clk) bus.ready = 1'b0;
    bcnt = 0;
    while (bus.busy && bcnt < 6000) begin
      bcnt++;
      bus.ready = (toggle && bcnt < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    bus.ready = 1'b0;
    chk({nm, "_busy_cycles"}, 32'(bcnt), 32'd5120);
    repeat (3) @(negedge clk);
    chk({nm, "_writes"}, 32'(wcnt), 32'd1024);
    chk({nm, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
    chk({nm, "_crd"}, 32'(bus.crd), 32'd0);
    chk({nm, "_cwr"}, 32'(bus.cwr), 32'd0);
    chk({nm, "_caddr_rd"}, 32'(bus.caddr_rd), 32'd0);
    chk({nm, "_caddr_wr"}, 32'(bus.caddr_wr), 32'd0);
    chk({nm, "_cdata_wr"}, 32'(bus.cdata_wr), 32'd0);
    chk({nm, "_csel"}, 32'(bus.csel), 32'd0);
  endtask

  initial begin
    bus.ready = 1'b0;
    for (int i = 0; i < 4096; i++) begin l0[i] = '0; l1[i] = 20'hAAAAA; end
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // all-zero map
    push_run(20'h0, 1'b0);
    run("zero", 1'b0);
    chk("zero_l1_0", 32'(l1[0]), 32'h0);
    chk("zero_l1_1023", 32'(l1[1023]), 32'h0);

    // ramp map, with ready toggled during busy
    for (int i = 0; i < 4096; i++) l0[i] = 20'(i);
    push_run(20'h0, 1'b1);
    run("ramp", 1'b1);
    chk("ramp_l1_0", 32'(l1[0]), 32'h41);
    chk("ramp_l1_1023", 32'(l1[1023]), 32'hFFF);

    // max moved through each quadrant position
    fill_quad(20'h9, 20'h5, 20'h3, 20'h1); push_run(20'h9, 1'b0); run("quad_p0", 1'b0);
    fill_quad(20'h5, 20'h9, 20'h3, 20'h1); push_run(20'h9, 1'b0); run("quad_p1", 1'b0);
    fill_quad(20'h5, 20'h3, 20'h9, 20'h1); push_run(20'h9, 1'b0); run("quad_p2", 1'b0);
    fill_quad(20'h5, 20'h3, 20'h1, 20'h9); push_run(20'h9, 1'b0); run("quad_p3", 1'b0);
    chk("quad_l1_0", 32'(l1[0]), 32'h9);

    // all-negative quadrant: signed compare, optional clamp
    fill_quad(20'hFFFFF, 20'hFFFFE, 20'h80000, 20'hFFFFD);
`ifdef MAXPOOL_RELU_EN
    push_run(20'h00000, 1'b0);
    run("neg", 1'b0);
    chk("neg_l1_0", 32'(l1[0]), 32'h00000);
`else
    push_run(20'hFFFFF, 1'b0);
    run("neg", 1'b0);
    chk("neg_l1_0", 32'(l1[0]), 32'hFFFFF);
`endif

    // reset in mid-run, then a full ramp run
    for (int i = 0; i < 4096; i++) l0[i] = 20'(i);
    push_run(20'h0, 1'b1);
    @(negedge clk) bus.ready = 1'b1;
    @(negedge clk) bus.ready = 1'b0;
    repeat (1999) @(negedge clk);
    chk("abort_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    chk_idle_outputs("abort");
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_cwr", 32'(bus.cwr), 32'd0);
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_abort_idle_cwr", 32'(bus.cwr), 32'd0);
    end
    push_run(20'h0, 1'b1);
    run("rerun", 1'b0);
    chk("rerun_l1_1023", 32'(l1[1023]), 32'hFFF);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
